// File: rtl/pixel_pal.sv
// pixel_pal: attribute/glyph bit -> CW-bit RGB with aligned syncs; 2 pixclk enables latency, no backpressure.
// Optional 16-entry CPU-writable palette when PIXEL_PALETTE_EN is defined; fixed colour mapping otherwise.
module pixel_pal #(
    parameter int CW           = 3,
    parameter int BLINK_FRAMES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pixclk,
    input  logic [7:0]      attcode,
    input  logic            pixel,
    input  logic            blank,
    input  logic            hsync_in,
    input  logic            vsync_in,
`ifdef PIXEL_PALETTE_EN
    input  logic            pal_we,
    input  logic [3:0]      pal_addr,
    input  logic [3*CW-1:0] pal_data,
`endif
    output logic            blink_state,
    output logic            hsync,
    output logic            vsync,
    output logic [CW-1:0]   r,
    output logic [CW-1:0]   g,
    output logic [CW-1:0]   b
);

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    function automatic logic [CW-1:0] chan_map(input logic c, input logic inten);
        logic [CW-1:0] v;
        v         = {CW{c & inten}};
        v[CW-1]   = c;
        v[CW-2]   = inten;
        return v;
    endfunction

    function automatic logic [3*CW-1:0] fixed_map(input logic [3:0] idx);
        return {chan_map(idx[2], idx[3]), chan_map(idx[1], idx[3]), chan_map(idx[0], idx[3])};
    endfunction

    logic [7:0]      s1_att;
    logic            s1_pixel;
    logic            s1_blank;
    logic            s1_hs;
    logic            s1_vs;
    logic            vs_prev;
    logic [7:0]      blink_cnt;
    logic            fg;
    logic [3:0]      col_idx;
    logic [3*CW-1:0] colour;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_att   <= '0;
            s1_pixel <= 1'b0;
            s1_blank <= 1'b0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
        end else if (pixclk) begin
            s1_att   <= attcode;
            s1_pixel <= pixel;
            s1_blank <= blank;
            s1_hs    <= hsync_in;
            s1_vs    <= vsync_in;
        end
    end

    // Frame counter runs off the raw vsync_in so the phase flips at the frame boundary itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_prev     <= 1'b0;
            blink_cnt   <= '0;
            blink_state <= 1'b0;
        end else if (pixclk) begin
            vs_prev <= vsync_in;
            if (vsync_in && !vs_prev) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_state <= ~blink_state;
                end else begin
                    blink_cnt <= blink_cnt + 8'd1;
                end
            end
        end
    end

`ifdef PIXEL_PALETTE_EN
    logic [3*CW-1:0] pal [16];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) pal[i] <= fixed_map(4'(i));
        end else if (pal_we) begin
            pal[pal_addr] <= pal_data;
        end
    end
`endif

    // Bit 3 of the index is exactly the intensify term, since background never intensifies.
    always_comb begin
        fg      = s1_pixel & ~(s1_att[7] & blink_state);
        col_idx = fg ? s1_att[3:0] : {1'b0, s1_att[6:4]};
`ifdef PIXEL_PALETTE_EN
        colour  = pal[col_idx];
`else
        colour  = fixed_map(col_idx);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync <= 1'b0;
            vsync <= 1'b0;
            r     <= '0;
            g     <= '0;
            b     <= '0;
        end else if (pixclk) begin
            hsync     <= s1_hs;
            vsync     <= s1_vs;
            {r, g, b} <= s1_blank ? colour : '0;
        end
    end

endmodule

// File: tb/tb_pixel_pal.sv
// Randomized + directed bench for pixel_pal against a per-enable history model.
module tb_pixel_pal;
`ifdef PIXEL_PALETTE_EN
    localparam int CW = 8;
`else
    localparam int CW = 3;
`endif
    localparam int BF = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pixclk = 1'b0;
    logic [7:0]    attcode = '0;
    logic          pixel = 1'b0;
    logic          blank = 1'b0;
    logic          hsync_in = 1'b0;
    logic          vsync_in = 1'b0;
    logic          blink_state;
    logic          hsync;
    logic          vsync;
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
`ifdef PIXEL_PALETTE_EN
    logic            pal_we = 1'b0;
    logic [3:0]      pal_addr = '0;
    logic [3*CW-1:0] pal_data = '0;
    logic            wr_en = 1'b0;
    logic [3:0]      wr_addr = '0;
    logic [3*CW-1:0] wr_data = '0;
    logic [3*CW-1:0] pal_m [16];
`endif

    int checks = 0;
    int errors = 0;
    int k = 0;
    logic [7:0] e_att [0:4095];
    logic       e_px  [0:4095];
    logic       e_bl  [0:4095];
    logic       e_hs  [0:4095];
    logic       e_vs  [0:4095];
    int         edges [0:4095];

    pixel_pal #(.CW(CW), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .pixclk(pixclk), .attcode(attcode), .pixel(pixel),
        .blank(blank), .hsync_in(hsync_in), .vsync_in(vsync_in),
`ifdef PIXEL_PALETTE_EN
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
`endif
        .blink_state(blink_state), .hsync(hsync), .vsync(vsync), .r(r), .g(g), .b(b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] chv(input logic c, input logic i);
        int unsigned base;
        base = 32'd1 << (CW - 2);
        return CW'((c ? 2 * base : 32'd0) + (i ? base : 32'd0) + ((c && i) ? base - 1 : 32'd0));
    endfunction

    function automatic logic blink_of(input int j);
        return ((edges[j] / BF) % 2) == 1;
    endfunction

    // Output produced from the inputs of history entry j and the blink phase in force after it.
    function automatic logic [3*CW-1:0] exp_rgb(input int j);
        logic       fg;
        logic       inten;
        logic [2:0] sel;
        fg = e_px[j] && !(e_att[j][7] && blink_of(j));
        if (!e_bl[j]) return '0;
        inten = fg && e_att[j][3];
        sel   = fg ? e_att[j][2:0] : e_att[j][6:4];
`ifdef PIXEL_PALETTE_EN
        return pal_m[{inten, sel}];
`else
        return {chv(sel[2], inten), chv(sel[1], inten), chv(sel[0], inten)};
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        pixclk = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        k = 0;
`ifdef PIXEL_PALETTE_EN
        for (int i = 0; i < 16; i++) begin
            logic [3:0] iv;
            iv = 4'(i);
            pal_m[i] = {chv(iv[2], iv[3]), chv(iv[1], iv[3]), chv(iv[0], iv[3])};
        end
`endif
        chk("rst_rgb", 32'({r, g, b}), 32'd0);
        chk("rst_sync", 32'({hsync, vsync}), 32'd0);
        chk("rst_blink", 32'(blink_state), 32'd0);
    endtask

    task automatic step(input logic [7:0] att, input logic px, input logic bl,
                        input logic hs, input logic vs, input int gap);
        logic [3*CW-1:0] exp_c;
        k = k + 1;
        e_att[k] = att; e_px[k] = px; e_bl[k] = bl; e_hs[k] = hs; e_vs[k] = vs;
        edges[k] = edges[k-1] + ((vs && !e_vs[k-1]) ? 1 : 0);
        exp_c = exp_rgb(k - 1);
        attcode = att; pixel = px; blank = bl; hsync_in = hs; vsync_in = vs;
        pixclk = 1'b1;
`ifdef PIXEL_PALETTE_EN
        pal_we = wr_en; pal_addr = wr_addr; pal_data = wr_data;
`endif
        @(posedge clk);
        #1;
        pixclk = 1'b0;
`ifdef PIXEL_PALETTE_EN
        pal_we = 1'b0;
        if (wr_en) pal_m[wr_addr] = wr_data;
        wr_en = 1'b0;
`endif
        chk("rgb", 32'({r, g, b}), 32'(exp_c));
        chk("hsync", 32'(hsync), 32'(e_hs[k-1]));
        chk("vsync", 32'(vsync), 32'(e_vs[k-1]));
        chk("blink", 32'(blink_state), 32'(blink_of(k)));
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        if (gap > 0) begin
            chk("rgb_hold", 32'({r, g, b}), 32'(exp_c));
            chk("blink_hold", 32'(blink_state), 32'(blink_of(k)));
        end
    endtask

`ifdef PIXEL_PALETTE_EN
    task automatic pal_wr(input logic [3:0] addr, input logic [3*CW-1:0] data);
        pal_we = 1'b1; pal_addr = addr; pal_data = data;
        @(posedge clk);
        #1;
        pal_we = 1'b0;
        pal_m[addr] = data;
    endtask
`endif

    initial begin
        e_att[0] = '0; e_px[0] = 1'b0; e_bl[0] = 1'b0; e_hs[0] = 1'b0; e_vs[0] = 1'b0;
        edges[0] = 0;
        do_reset();

        // Colour with intensify, then background.
        step(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        step(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0, 1);
`ifndef PIXEL_PALETTE_EN
        chk("tp_fg_1c", 32'({r, g, b}), 32'h1D2);
`endif
        step(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        step(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 1);
`ifndef PIXEL_PALETTE_EN
        chk("tp_bg_1c", 32'({r, g, b}), 32'h004);
`endif

        // Blanked area: colour forced off, syncs still flow.
        step(8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        step(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1);
        step(8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1);
        chk("tp_blank_rgb", 32'({r, g, b}), 32'd0);
        step(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1);

        // Blink phase over four vsync rising edges.
        do_reset();
        step(8'h87, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        step(8'h87, 1'b1, 1'b1, 1'b0, 1'b1, 1);
        step(8'h87, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        step(8'h87, 1'b1, 1'b1, 1'b0, 1'b1, 1);
        chk("tp_blink_on", 32'(blink_state), 32'd1);
        step(8'h87, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        chk("tp_blink_black", 32'({r, g, b}), 32'd0);
        step(8'h87, 1'b1, 1'b1, 1'b0, 1'b1, 1);
        step(8'h87, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        step(8'h87, 1'b1, 1'b1, 1'b0, 1'b1, 1);
        chk("tp_blink_off", 32'(blink_state), 32'd0);
        step(8'h87, 1'b1, 1'b1, 1'b1, 1'b0, 1);
`ifndef PIXEL_PALETTE_EN
        chk("tp_blink_vis", 32'({r, g, b}), 32'h124);
`endif

        // Mid-line reset with live outputs, then the counter must restart from zero.
        do_reset();
        step(8'h87, 1'b1, 1'b1, 1'b0, 1'b1, 1);
        step(8'h87, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        chk("rst_cnt_half", 32'(blink_state), 32'd0);
        step(8'h87, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        chk("rst_cnt_full", 32'(blink_state), 32'd1);

`ifdef PIXEL_PALETTE_EN
        do_reset();
        pal_wr(4'hA, 24'h123456);
        step(8'h0A, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        step(8'h0A, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        chk("pal_written", 32'({r, g, b}), 32'h123456);
        step(8'h09, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        step(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        wr_en = 1'b1; wr_addr = 4'h1; wr_data = 24'hABCDEF;
        step(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        chk("pal_rw_old", 32'({r, g, b}), 32'h000080);
        step(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        chk("pal_rw_new", 32'({r, g, b}), 32'hABCDEF);
`endif

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
`ifdef PIXEL_PALETTE_EN
                if ($urandom_range(0, 7) == 0) begin
                    wr_en = 1'b1; wr_addr = 4'($urandom); wr_data = (3*CW)'($urandom);
                end
`endif
                step(8'($urandom), 1'($urandom), ($urandom_range(0, 4) != 0), 1'($urandom),
                     ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
